// File: rtl/pac_pkg.sv
// Shared definitions for the packet dispatch block: beat codes,
// action field layout, read-side states and the action decoder.
package pac_pkg;

    localparam logic [1:0] BEAT_HEAD = 2'b01;
    localparam logic [1:0] BEAT_MID  = 2'b11;
    localparam logic [1:0] BEAT_TAIL = 2'b10;

    localparam logic [1:0] MODE_UNI = 2'b00;
    localparam logic [1:0] MODE_BC  = 2'b10;

    localparam int MODE_HI = 10;
    localparam int MODE_LO = 9;
    localparam int TYPE_HI = 8;
    localparam int TYPE_LO = 6;
    localparam int PORT_HI = 5;
    localparam int PORT_LO = 0;

    localparam int PKT_W = 134;
    localparam int ACT_W = 11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECIDE,
        S_SEND,
        S_DROP
    } state_t;

    // Returns {port1, port0} targets; 2'b00 means drop.
    function automatic logic [1:0] decode(input logic [ACT_W-1:0] act,
                                          input logic sts);
        logic [1:0] mode;
        logic [5:0] port;
        mode   = act[MODE_HI:MODE_LO];
        port   = act[PORT_HI:PORT_LO];
        decode = 2'b00;
        if (sts) begin
            if (mode == MODE_BC) begin
                decode = 2'b11;
            end else if (mode == MODE_UNI) begin
                if (port == 6'd0)
                    decode = 2'b01;
                else if (port == 6'd1)
                    decode = 2'b10;
            end
        end
    endfunction

endpackage

// File: rtl/pac_sfifo.sv
// Synchronous show-ahead FIFO with free-word count.
// Writes to a full FIFO are discarded, even if a read happens that cycle.
module pac_sfifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [AW:0]   free
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [AW:0]  used;
    logic         full;
    logic         do_wr;
    logic         do_rd;

    assign used  = wptr - rptr;
    assign full  = used[AW];
    assign empty = (used == '0);
    assign free  = DEPTH_V - used;
    assign rdata = mem[rptr[AW-1:0]];
    assign do_wr = wr && !full;
    assign do_rd = rd && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_wr)
                wptr <= wptr + 1'b1;
            if (do_rd)
                rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/pac_dispatch.sv
// Store-and-forward dispatcher: buffers whole packets, decodes the
// action and forwards to egress port 0, port 1, both, or drops.
module pac_dispatch
    import pac_pkg::*;
#(
    parameter int DATA_AW  = 8,
    parameter int ACT_AW   = 4,
    parameter int ALF_FREE = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [PKT_W-1:0]   in_pac_data,
    input  logic               in_pac_data_wr,
    input  logic               in_pac_valid,
    input  logic               in_pac_valid_wr,
    input  logic [ACT_W-1:0]   in_pac_action,
    input  logic               in_pac_action_wr,
    output logic               out_pac_alf,
    output logic [PKT_W-1:0]   out_port0_data,
    output logic               out_port0_data_wr,
    output logic               out_port0_valid,
    output logic               out_port0_valid_wr,
    input  logic               in_port0_alf,
    output logic [PKT_W-1:0]   out_port1_data,
    output logic               out_port1_data_wr,
    output logic               out_port1_valid,
    output logic               out_port1_valid_wr,
    input  logic               in_port1_alf,
    output logic [31:0]        tx_cnt0,
    output logic [31:0]        tx_cnt1,
    output logic [31:0]        drop_cnt,
    output logic               ovf_err
);

    logic [PKT_W-1:0] d_rdata;
    logic [ACT_W-1:0] a_rdata;
    logic             s_rdata;
    logic             d_empty;
    logic             a_empty;
    logic             s_empty;
    logic [DATA_AW:0] d_free;
    logic [ACT_AW:0]  a_free;
    logic [ACT_AW:0]  s_free;
    logic             ready;
    logic             ctl_rd;
    logic             d_rd;
    logic             is_tail;
    logic             stall;
    logic             ovf;
    logic [1:0]       tgt;
    state_t           state;

    assign ready   = !a_empty && !s_empty;
    assign ctl_rd  = (state == S_IDLE) && ready;
    assign d_rd    = ((state == S_SEND) || (state == S_DROP)) && !d_empty;
    assign is_tail = (d_rdata[PKT_W-1:PKT_W-2] == BEAT_TAIL);
    assign stall   = (tgt[0] & in_port0_alf) | (tgt[1] & in_port1_alf);
    assign ovf     = (in_pac_data_wr   && (d_free == '0)) ||
                     (in_pac_action_wr && (a_free == '0)) ||
                     (in_pac_valid_wr  && (s_free == '0));

    pac_sfifo #(.W(PKT_W), .AW(DATA_AW)) u_data (
        .clk   (clk),
        .rst   (rst),
        .wr    (in_pac_data_wr),
        .wdata (in_pac_data),
        .rd    (d_rd),
        .rdata (d_rdata),
        .empty (d_empty),
        .free  (d_free)
    );

    pac_sfifo #(.W(ACT_W), .AW(ACT_AW)) u_act (
        .clk   (clk),
        .rst   (rst),
        .wr    (in_pac_action_wr),
        .wdata (in_pac_action),
        .rd    (ctl_rd),
        .rdata (a_rdata),
        .empty (a_empty),
        .free  (a_free)
    );

    pac_sfifo #(.W(1), .AW(ACT_AW)) u_sts (
        .clk   (clk),
        .rst   (rst),
        .wr    (in_pac_valid_wr),
        .wdata (in_pac_valid),
        .rd    (ctl_rd),
        .rdata (s_rdata),
        .empty (s_empty),
        .free  (s_free)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            tgt                <= 2'b00;
            out_pac_alf        <= 1'b0;
            out_port0_data     <= '0;
            out_port0_data_wr  <= 1'b0;
            out_port0_valid    <= 1'b0;
            out_port0_valid_wr <= 1'b0;
            out_port1_data     <= '0;
            out_port1_data_wr  <= 1'b0;
            out_port1_valid    <= 1'b0;
            out_port1_valid_wr <= 1'b0;
            tx_cnt0            <= '0;
            tx_cnt1            <= '0;
            drop_cnt           <= '0;
            ovf_err            <= 1'b0;
        end else begin
            out_pac_alf        <= d_free < (DATA_AW+1)'(ALF_FREE);
            out_port0_data_wr  <= 1'b0;
            out_port0_valid    <= 1'b0;
            out_port0_valid_wr <= 1'b0;
            out_port1_data_wr  <= 1'b0;
            out_port1_valid    <= 1'b0;
            out_port1_valid_wr <= 1'b0;
            if (ovf)
                ovf_err <= 1'b1;
            unique case (state)
                S_IDLE: begin
                    if (ready) begin
                        tgt   <= decode(a_rdata, s_rdata);
                        state <= S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (tgt == 2'b00)
                        state <= S_DROP;
                    else if (!stall)
                        state <= S_SEND;
                end
                S_SEND: begin
                    if (d_rd) begin
                        if (tgt[0]) begin
                            out_port0_data     <= d_rdata;
                            out_port0_data_wr  <= 1'b1;
                            out_port0_valid    <= is_tail;
                            out_port0_valid_wr <= is_tail;
                        end
                        if (tgt[1]) begin
                            out_port1_data     <= d_rdata;
                            out_port1_data_wr  <= 1'b1;
                            out_port1_valid    <= is_tail;
                            out_port1_valid_wr <= is_tail;
                        end
                        if (is_tail) begin
                            tx_cnt0 <= tx_cnt0 + 32'(tgt[0]);
                            tx_cnt1 <= tx_cnt1 + 32'(tgt[1]);
                            state   <= S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (d_rd && is_tail) begin
                        drop_cnt <= drop_cnt + 32'd1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pac_dispatch.sv
// Scoreboard bench for pac_dispatch: directed packets push expected
// egress beats into per-port queues that a negedge monitor consumes.
module tb_pac_dispatch;
    import pac_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [PKT_W-1:0]   in_pac_data = '0;
    logic               in_pac_data_wr = 1'b0;
    logic               in_pac_valid = 1'b0;
    logic               in_pac_valid_wr = 1'b0;
    logic [ACT_W-1:0]   in_pac_action = '0;
    logic               in_pac_action_wr = 1'b0;
    logic               out_pac_alf;
    logic [PKT_W-1:0]   out_port0_data;
    logic               out_port0_data_wr;
    logic               out_port0_valid;
    logic               out_port0_valid_wr;
    logic               in_port0_alf = 1'b0;
    logic [PKT_W-1:0]   out_port1_data;
    logic               out_port1_data_wr;
    logic               out_port1_valid;
    logic               out_port1_valid_wr;
    logic               in_port1_alf = 1'b0;
    logic [31:0]        tx_cnt0;
    logic [31:0]        tx_cnt1;
    logic [31:0]        drop_cnt;
    logic               ovf_err;

    typedef struct packed {
        logic [PKT_W-1:0] d;
        logic             last;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    logic bc_chk = 1'b0;

    pac_dispatch dut (
        .clk                (clk),
        .rst                (rst),
        .in_pac_data        (in_pac_data),
        .in_pac_data_wr     (in_pac_data_wr),
        .in_pac_valid       (in_pac_valid),
        .in_pac_valid_wr    (in_pac_valid_wr),
        .in_pac_action      (in_pac_action),
        .in_pac_action_wr   (in_pac_action_wr),
        .out_pac_alf        (out_pac_alf),
        .out_port0_data     (out_port0_data),
        .out_port0_data_wr  (out_port0_data_wr),
        .out_port0_valid    (out_port0_valid),
        .out_port0_valid_wr (out_port0_valid_wr),
        .in_port0_alf       (in_port0_alf),
        .out_port1_data     (out_port1_data),
        .out_port1_data_wr  (out_port1_data_wr),
        .out_port1_valid    (out_port1_valid),
        .out_port1_valid_wr (out_port1_valid_wr),
        .in_port1_alf       (in_port1_alf),
        .tx_cnt0            (tx_cnt0),
        .tx_cnt1            (tx_cnt1),
        .drop_cnt           (drop_cnt),
        .ovf_err            (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [PKT_W-1:0] act,
                       input logic [PKT_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mon(input int p, input logic [PKT_W-1:0] d,
                       input logic v, input logic vw);
        exp_t e;
        if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat port%0d: got %h expected none", p, d);
        end else begin
            e = (p == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("p%0d_data", p), d, e.d);
            chk($sformatf("p%0d_valid", p), PKT_W'(v), PKT_W'(e.last));
            chk($sformatf("p%0d_valid_wr", p), PKT_W'(vw), PKT_W'(e.last));
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_port0_data_wr)
                mon(0, out_port0_data, out_port0_valid, out_port0_valid_wr);
            if (out_port1_data_wr)
                mon(1, out_port1_data, out_port1_valid, out_port1_valid_wr);
            if (bc_chk && (out_port0_data_wr || out_port1_data_wr))
                chk("bc_sync", PKT_W'({out_port0_data_wr, out_port1_data_wr}),
                    PKT_W'(2'b11));
        end
    end

    task automatic send_pkt(input int n, input logic [ACT_W-1:0] act,
                            input logic v, input logic [1:0] tgt,
                            input int base);
        exp_t e;
        logic [1:0] code;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            code = (i == 0) ? BEAT_HEAD : (i == n - 1) ? BEAT_TAIL : BEAT_MID;
            in_pac_data      = {code, 132'(base + i)};
            in_pac_data_wr   = 1'b1;
            in_pac_action    = act;
            in_pac_action_wr = (i == 0);
            in_pac_valid     = v;
            in_pac_valid_wr  = (i == n - 1);
            e.d    = in_pac_data;
            e.last = (i == n - 1);
            if (tgt[0])
                q0.push_back(e);
            if (tgt[1])
                q1.push_back(e);
        end
        @(posedge clk);
        #1;
        in_pac_data_wr   = 1'b0;
        in_pac_action_wr = 1'b0;
        in_pac_valid_wr  = 1'b0;
    endtask

    task automatic wr_beats(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            in_pac_data    = {BEAT_MID, 132'(i)};
            in_pac_data_wr = 1'b1;
        end
        @(posedge clk);
        #1;
        in_pac_data_wr = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 80 && (q0.size() != 0 || q1.size() != 0); i++)
            @(posedge clk);
        repeat (4) @(posedge clk);
        #2;
        chk(name, PKT_W'(q0.size() + q1.size()), '0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        chk("rst_p0_wr", PKT_W'(out_port0_data_wr), '0);
        chk("rst_p1_wr", PKT_W'(out_port1_data_wr), '0);
        chk("rst_cnts", PKT_W'({tx_cnt0, tx_cnt1, drop_cnt}), '0);
        chk("rst_flags", PKT_W'({ovf_err, out_pac_alf}), '0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outs", PKT_W'({out_port0_data_wr, out_port1_data_wr,
            out_port0_valid_wr, out_port1_valid_wr, out_pac_alf, ovf_err}), '0);
        chk("reset_cnts", PKT_W'({tx_cnt0, tx_cnt1, drop_cnt}), '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        send_pkt(4, {2'b00, 3'd2, 6'd1}, 1'b1, 2'b10, 32'h100);
        drain("uni_drain");
        chk("uni_tx1", PKT_W'(tx_cnt1), PKT_W'(1));
        chk("uni_tx0", PKT_W'(tx_cnt0), PKT_W'(0));

        bc_chk = 1'b1;
        send_pkt(3, {2'b10, 3'd0, 6'd5}, 1'b1, 2'b11, 32'h200);
        drain("bc_drain");
        bc_chk = 1'b0;
        chk("bc_tx0", PKT_W'(tx_cnt0), PKT_W'(1));
        chk("bc_tx1", PKT_W'(tx_cnt1), PKT_W'(2));

        send_pkt(3, {2'b00, 3'd0, 6'd2}, 1'b1, 2'b00, 32'h300);
        send_pkt(2, {2'b01, 3'd0, 6'd0}, 1'b1, 2'b00, 32'h310);
        send_pkt(5, {2'b00, 3'd0, 6'd0}, 1'b0, 2'b00, 32'h320);
        repeat (30) @(posedge clk);
        #2;
        chk("drop_cnt", PKT_W'(drop_cnt), PKT_W'(3));
        send_pkt(2, {2'b00, 3'd1, 6'd0}, 1'b1, 2'b01, 32'h400);
        drain("post_drop_drain");
        chk("post_drop_tx0", PKT_W'(tx_cnt0), PKT_W'(2));

        in_port0_alf = 1'b1;
        send_pkt(4, {2'b00, 3'd0, 6'd0}, 1'b1, 2'b01, 32'h500);
        repeat (20) @(posedge clk);
        #2;
        chk("bp_hold", PKT_W'(q0.size()), PKT_W'(4));
        #1;
        in_port0_alf = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #2;
            cnt++;
            if (out_port0_data_wr)
                break;
        end
        chk("bp_release_lat", PKT_W'(cnt), PKT_W'(2));
        in_port0_alf = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("bp_no_pause", PKT_W'(q0.size()), '0);
        in_port0_alf = 1'b0;
        chk("bp_tx0", PKT_W'(tx_cnt0), PKT_W'(3));

        wr_beats(190);
        repeat (2) @(posedge clk);
        #2;
        chk("alf_low_190", PKT_W'(out_pac_alf), '0);
        wr_beats(10);
        repeat (2) @(posedge clk);
        #2;
        chk("alf_high_200", PKT_W'(out_pac_alf), PKT_W'(1));
        wr_beats(56);
        repeat (2) @(posedge clk);
        #2;
        chk("ovf_at_256", PKT_W'(ovf_err), '0);
        wr_beats(1);
        repeat (2) @(posedge clk);
        #2;
        chk("ovf_at_257", PKT_W'(ovf_err), PKT_W'(1));
        do_reset();

        send_pkt(8, {2'b00, 3'd0, 6'd1}, 1'b1, 2'b10, 32'h600);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #2;
            if (out_port1_data_wr) begin
                cnt = 1;
                break;
            end
        end
        chk("send_started", PKT_W'(cnt), PKT_W'(1));
        do_reset();
        send_pkt(4, {2'b00, 3'd0, 6'd1}, 1'b1, 2'b10, 32'h700);
        drain("post_rst_drain");
        chk("post_rst_tx1", PKT_W'(tx_cnt1), PKT_W'(1));
        chk("post_rst_tx0", PKT_W'(tx_cnt0), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
